// File: rtl/reg_dump_unit.sv
// Debug responder: halts the core, reads the register file in index order and
// streams (index, value) pairs over a valid/ready port, then releases the halt.
module reg_dump_unit #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dump_req,
  output logic              halt_req,
  input  logic              halt_ack,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HALT_WAIT = 3'd1,
    READ      = 3'd2,
    SEND      = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_next;
  logic              halt_req_next;
  logic              busy_next;
  logic              done_next;
  logic              out_valid_next;
  logic              handshake;

  assign handshake = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (dump_req) next_state = HALT_WAIT;
        else          next_state = IDLE;
      end
      HALT_WAIT: begin
        if (halt_ack) next_state = READ;
        else          next_state = HALT_WAIT;
      end
      READ: next_state = SEND;
      SEND: begin
        if (handshake) next_state = out_last ? DONE : READ;
        else           next_state = SEND;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode: next values of the registered outputs and the index
  always_comb begin
    idx_next       = idx;
    halt_req_next  = (next_state == HALT_WAIT) || (next_state == READ) || (next_state == SEND);
    busy_next      = (next_state != IDLE);
    done_next      = (next_state == DONE);
    out_valid_next = (next_state == SEND);
    case (state)
      IDLE: begin
        if (dump_req) idx_next = {ADDR_W{1'b0}};
        else          idx_next = idx;
      end
      SEND: begin
        if (handshake && !out_last) idx_next = idx + ADDR_W'(1);
        else                        idx_next = idx;
      end
      DONE:    idx_next = {ADDR_W{1'b0}};
      default: idx_next = idx;
    endcase
  end

  // Output and datapath registers; read address is loaded on entry to READ so it is valid for that cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx        <= {ADDR_W{1'b0}};
      halt_req   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      out_valid  <= 1'b0;
      rf_rd_addr <= {ADDR_W{1'b0}};
      out_index  <= {ADDR_W{1'b0}};
      out_data   <= {DATA_W{1'b0}};
      out_last   <= 1'b0;
    end else begin
      idx       <= idx_next;
      halt_req  <= halt_req_next;
      busy      <= busy_next;
      done      <= done_next;
      out_valid <= out_valid_next;
      if (next_state == READ) rf_rd_addr <= idx_next;
      if (state == READ) begin
        out_data  <= rf_rd_data;
        out_index <= idx;
        out_last  <= (idx == LAST_IDX);
      end else if (state == DONE) begin
        out_last  <= 1'b0;
      end
    end
  end

endmodule
